// File: rtl/ysyx_22041211_axi_clint_pkg.sv
// Shared CLINT definitions: address map, AXI response codes, FSM encodings and the
// read-response payload used by ysyx_22041211_axi_clint.
package ysyx_22041211_axi_clint_pkg;

    localparam logic [31:0] CLINT_BASE      = 32'h0200_0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MTIME_LO,
        SEL_MTIME_HI,
        SEL_CMP_LO,
        SEL_CMP_HI
    } reg_sel_e;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_beat_t;

    // Only the low 16 address bits select a register; mtimecmp exists only when enabled.
    function automatic reg_sel_e decode_off(input logic [15:0] off, input logic cmp_en);
        reg_sel_e sel;
        sel = SEL_NONE;
        case (off)
            OFF_MTIME_LO:    sel = SEL_MTIME_LO;
            OFF_MTIME_HI:    sel = SEL_MTIME_HI;
            OFF_MTIMECMP_LO: sel = cmp_en ? SEL_CMP_LO : SEL_NONE;
            OFF_MTIMECMP_HI: sel = cmp_en ? SEL_CMP_HI : SEL_NONE;
            default:         sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22041211_axi_clint_if.sv
// AXI4 single-beat bus bundle between the Xbar (master) and the CLINT responder (slave).
interface ysyx_22041211_axi_clint_if #(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32
);
    logic [ADDR_LEN-1:0] axi_addr_r_addr;
    logic                axi_addr_r_valid;
    logic                axi_addr_r_ready;
    logic [3:0]          axi_addr_r_id;
    logic [DATA_LEN-1:0] axi_r_data;
    logic [1:0]          axi_r_resp;
    logic                axi_r_valid;
    logic                axi_r_ready;
    logic                axi_r_last;
    logic [3:0]          axi_r_id;
    logic [ADDR_LEN-1:0] axi_addr_w_addr;
    logic                axi_addr_w_valid;
    logic                axi_addr_w_ready;
    logic [3:0]          axi_addr_w_id;
    logic [DATA_LEN-1:0] axi_w_data;
    logic [3:0]          axi_w_strb;
    logic                axi_w_valid;
    logic                axi_w_ready;
    logic [1:0]          axi_bkwd_resp;
    logic                axi_bkwd_valid;
    logic                axi_bkwd_ready;
    logic [3:0]          axi_bkwd_id;

    modport master (
        output axi_addr_r_addr, axi_addr_r_valid, axi_addr_r_id, axi_r_ready,
               axi_addr_w_addr, axi_addr_w_valid, axi_addr_w_id,
               axi_w_data, axi_w_strb, axi_w_valid, axi_bkwd_ready,
        input  axi_addr_r_ready, axi_r_data, axi_r_resp, axi_r_valid, axi_r_last, axi_r_id,
               axi_addr_w_ready, axi_w_ready, axi_bkwd_resp, axi_bkwd_valid, axi_bkwd_id
    );

    modport slave (
        input  axi_addr_r_addr, axi_addr_r_valid, axi_addr_r_id, axi_r_ready,
               axi_addr_w_addr, axi_addr_w_valid, axi_addr_w_id,
               axi_w_data, axi_w_strb, axi_w_valid, axi_bkwd_ready,
        output axi_addr_r_ready, axi_r_data, axi_r_resp, axi_r_valid, axi_r_last, axi_r_id,
               axi_addr_w_ready, axi_w_ready, axi_bkwd_resp, axi_bkwd_valid, axi_bkwd_id
    );
endinterface

// File: rtl/ysyx_22041211_clint_mtime.sv
// Free-running 64-bit mtime with prescaler; a strobed write to one half replaces that
// cycle's increment and leaves the other half as it was.
module ysyx_22041211_clint_mtime
    import ysyx_22041211_axi_clint_pkg::*;
#(
    parameter int unsigned MTIME_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    output logic [63:0] mtime_o
);
    localparam int unsigned PRE_W = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MTIME_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [63:0]      mtime_q, mtime_d;
    logic             tick;

    always_comb begin
        tick    = (pre_q == PRE_MAX);
        pre_d   = tick ? '0 : pre_q + PRE_W'(1);
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_lo_i || wr_hi_i) begin
            mtime_d = mtime_q;
            if (wr_lo_i) mtime_d[31:0]  = strb_merge(mtime_q[31:0],  wr_data_i, wr_strb_i);
            if (wr_hi_i) mtime_d[63:32] = strb_merge(mtime_q[63:32], wr_data_i, wr_strb_i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q   <= '0;
            mtime_q <= '0;
        end else begin
            pre_q   <= pre_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/ysyx_22041211_axi_clint.sv
// AXI4 CLINT responder: independent read and write FSMs in front of mtime.
// Define CLINT_MTIMECMP_EN to add mtimecmp at 0x4000/0x4004 and drive timer_irq_o.
module ysyx_22041211_axi_clint
    import ysyx_22041211_axi_clint_pkg::*;
#(
    parameter int unsigned ADDR_LEN  = 32,
    parameter int unsigned DATA_LEN  = 32,
    parameter int unsigned MTIME_DIV = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    ysyx_22041211_axi_clint_if.slave      axi,
    output logic                          timer_irq_o
);
`ifdef CLINT_MTIMECMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    // ---------------- read channel ----------------
    rd_state_e           rd_state_q, rd_state_d;
    rd_beat_t            rd_beat_q, rd_beat_d;
    reg_sel_e            rd_sel;
    logic [DATA_LEN-1:0] rd_val;

    always_comb begin
        rd_sel = decode_off(axi.axi_addr_r_addr[15:0], CMP_EN);
        rd_val = '0;
        case (rd_sel)
            SEL_MTIME_LO: rd_val = mtime[31:0];
            SEL_MTIME_HI: rd_val = mtime[63:32];
            SEL_CMP_LO:   rd_val = mtimecmp[31:0];
            SEL_CMP_HI:   rd_val = mtimecmp[63:32];
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_beat_d  = rd_beat_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (axi.axi_addr_r_valid) begin
                    rd_state_d     = RD_RESP;
                    rd_beat_d.id   = axi.axi_addr_r_id;
                    rd_beat_d.data = rd_val;
                    rd_beat_d.resp = (rd_sel == SEL_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                end
            end
            RD_RESP: begin
                if (axi.axi_r_ready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_q <= RD_IDLE;
            rd_beat_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_beat_q  <= rd_beat_d;
        end
    end

    assign axi.axi_addr_r_ready = (rd_state_q == RD_IDLE);
    assign axi.axi_r_valid      = (rd_state_q == RD_RESP);
    assign axi.axi_r_last       = (rd_state_q == RD_RESP);
    assign axi.axi_r_data       = rd_beat_q.data;
    assign axi.axi_r_resp       = rd_beat_q.resp;
    assign axi.axi_r_id         = rd_beat_q.id;

    // ---------------- write channel ----------------
    wr_state_e   wr_state_q, wr_state_d;
    logic [15:0] aw_off_q, aw_off_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        aw_fire, w_fire, commit;
    logic [15:0] wr_off;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    reg_sel_e    wr_sel;

    assign axi.axi_addr_w_ready = (wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_W);
    assign axi.axi_w_ready      = (wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_AW);

    // Commit uses whichever beat is already latched, else the one handshaking now.
    always_comb begin
        aw_fire    = axi.axi_addr_w_valid && axi.axi_addr_w_ready;
        w_fire     = axi.axi_w_valid && axi.axi_w_ready;
        wr_off     = (wr_state_q == WR_HAVE_AW) ? aw_off_q : axi.axi_addr_w_addr[15:0];
        wr_data    = (wr_state_q == WR_HAVE_W)  ? w_data_q : axi.axi_w_data;
        wr_strb    = (wr_state_q == WR_HAVE_W)  ? w_strb_q : axi.axi_w_strb;
        wr_sel     = decode_off(wr_off, CMP_EN);
        wr_state_d = wr_state_q;
        aw_off_d   = aw_off_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        if (aw_fire) begin
            aw_off_d = axi.axi_addr_w_addr[15:0];
            bid_d    = axi.axi_addr_w_id;
        end
        if (w_fire) begin
            w_data_d = axi.axi_w_data;
            w_strb_d = axi.axi_w_strb;
        end
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_fire && w_fire) begin
                    wr_state_d = WR_RESP;
                    commit     = 1'b1;
                end else if (aw_fire) begin
                    wr_state_d = WR_HAVE_AW;
                end else if (w_fire) begin
                    wr_state_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_fire) begin
                    wr_state_d = WR_RESP;
                    commit     = 1'b1;
                end
            end
            WR_HAVE_W: begin
                if (aw_fire) begin
                    wr_state_d = WR_RESP;
                    commit     = 1'b1;
                end
            end
            WR_RESP: begin
                if (axi.axi_bkwd_ready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
        if (commit) bresp_d = (wr_sel == SEL_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            aw_off_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bid_q      <= '0;
            bresp_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_off_q   <= aw_off_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
        end
    end

    assign axi.axi_bkwd_valid = (wr_state_q == WR_RESP);
    assign axi.axi_bkwd_resp  = bresp_q;
    assign axi.axi_bkwd_id    = bid_q;

    ysyx_22041211_clint_mtime #(
        .MTIME_DIV (MTIME_DIV)
    ) u_mtime (
        .clock     (clock),
        .reset     (reset),
        .wr_lo_i   (commit && (wr_sel == SEL_MTIME_LO)),
        .wr_hi_i   (commit && (wr_sel == SEL_MTIME_HI)),
        .wr_data_i (wr_data),
        .wr_strb_i (wr_strb),
        .mtime_o   (mtime)
    );

`ifdef CLINT_MTIMECMP_EN
    logic [63:0] cmp_q, cmp_d;
    logic        irq_q;

    always_comb begin
        cmp_d = cmp_q;
        if (commit && (wr_sel == SEL_CMP_LO)) cmp_d[31:0]  = strb_merge(cmp_q[31:0],  wr_data, wr_strb);
        if (commit && (wr_sel == SEL_CMP_HI)) cmp_d[63:32] = strb_merge(cmp_q[63:32], wr_data, wr_strb);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmp_q <= '1;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= (mtime >= cmp_q);
        end
    end

    assign mtimecmp    = cmp_q;
    assign timer_irq_o = irq_q;
`else
    assign mtimecmp    = '1;
    assign timer_irq_o = 1'b0;
`endif

    // Upper address bits select the Xbar leg, not a register.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{axi.axi_addr_r_addr[ADDR_LEN-1:16], axi.axi_addr_w_addr[ADDR_LEN-1:16]};

endmodule

// File: tb/tb_ysyx_22041211_axi_clint.sv
// Directed, table-driven bench for ysyx_22041211_axi_clint (MTIME_DIV=1).
module tb_ysyx_22041211_axi_clint;

    localparam int MAXW = 64;
    localparam logic [31:0] B = 32'h0200_0000;
`ifdef CLINT_MTIMECMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic clock;
    logic reset;
    logic irq;
    int   n_checks;
    int   n_fail;

    ysyx_22041211_axi_clint_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

    ysyx_22041211_axi_clint #(
        .ADDR_LEN  (32),
        .DATA_LEN  (32),
        .MTIME_DIV (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .axi         (bus),
        .timer_irq_o (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  id;
        logic [1:0]  exp_resp;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input logic [63:0] act,
                             input logic [63:0] lo, input logic [63:0] hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake did not complete within %0d cycles", name, MAXW);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clock);
        bus.axi_addr_r_addr  = addr;
        bus.axi_addr_r_id    = id;
        bus.axi_addr_r_valid = 1'b1;
        n = 0;
        while (!bus.axi_addr_r_ready && n < MAXW) begin
            @(negedge clock);
            n++;
        end
        if (n >= MAXW) begin
            note_fail("ar_timeout");
            bus.axi_addr_r_valid = 1'b0;
            data = '0;
            resp = 2'b11;
            return;
        end
        @(negedge clock);
        bus.axi_addr_r_valid = 1'b0;
        chk("rvalid_after_ar", bus.axi_r_valid, 1'b1);
        chk("arready_while_r", bus.axi_addr_r_ready, 1'b0);
        chk("rid_echo", bus.axi_r_id, id);
        chk("rlast", bus.axi_r_last, 1'b1);
        data = bus.axi_r_data;
        resp = bus.axi_r_resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("rvalid_hold", bus.axi_r_valid, 1'b1);
            chk("rdata_hold", bus.axi_r_data, data);
            chk("rresp_hold", bus.axi_r_resp, resp);
            chk("arready_hold", bus.axi_addr_r_ready, 1'b0);
        end
        bus.axi_r_ready = 1'b1;
        @(negedge clock);
        bus.axi_r_ready = 1'b0;
        chk("rvalid_after_r", bus.axi_r_valid, 1'b0);
        chk("arready_after_r", bus.axi_addr_r_ready, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [3:0] id, input int aw_dly, input int w_dly, input int bhold,
                            output logic [1:0] resp);
        logic aw_done, w_done, aw_fire, w_fire;
        int c;
        aw_done = 1'b0; w_done = 1'b0; aw_fire = 1'b0; w_fire = 1'b0; c = 0;
        bus.axi_addr_w_addr = addr;
        bus.axi_addr_w_id   = id;
        bus.axi_w_data      = data;
        bus.axi_w_strb      = strb;
        while (!(aw_done && w_done) && c < MAXW) begin
            @(negedge clock);
            if (aw_fire) begin bus.axi_addr_w_valid = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin bus.axi_w_valid = 1'b0;      w_done  = 1'b1; end
            if (aw_done && !w_done) chk("awready_drop", bus.axi_addr_w_ready, 1'b0);
            if (w_done && !aw_done) chk("wready_drop", bus.axi_w_ready, 1'b0);
            if (!aw_done && c >= aw_dly) bus.axi_addr_w_valid = 1'b1;
            if (!w_done && c >= w_dly)   bus.axi_w_valid = 1'b1;
            aw_fire = bus.axi_addr_w_valid && bus.axi_addr_w_ready;
            w_fire  = bus.axi_w_valid && bus.axi_w_ready;
            c++;
        end
        if (!(aw_done && w_done)) begin
            note_fail("aw_w_timeout");
            bus.axi_addr_w_valid = 1'b0;
            bus.axi_w_valid = 1'b0;
            resp = 2'b11;
            return;
        end
        chk("bvalid_after_commit", bus.axi_bkwd_valid, 1'b1);
        chk("bid_echo", bus.axi_bkwd_id, id);
        resp = bus.axi_bkwd_resp;
        for (int i = 0; i < bhold; i++) begin
            @(negedge clock);
            chk("bvalid_hold", bus.axi_bkwd_valid, 1'b1);
            chk("bresp_hold", bus.axi_bkwd_resp, resp);
            chk("bid_hold", bus.axi_bkwd_id, id);
            chk("awready_hold", bus.axi_addr_w_ready, 1'b0);
        end
        bus.axi_bkwd_ready = 1'b1;
        @(negedge clock);
        bus.axi_bkwd_ready = 1'b0;
        chk("bvalid_after_b", bus.axi_bkwd_valid, 1'b0);
        chk("awready_after_b", bus.axi_addr_w_ready, 1'b1);
        chk("wready_after_b", bus.axi_w_ready, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2;
        int          n;

        n_checks = 0;
        n_fail   = 0;
        bus.axi_addr_r_addr = '0; bus.axi_addr_r_valid = 1'b0; bus.axi_addr_r_id = '0;
        bus.axi_r_ready = 1'b0;
        bus.axi_addr_w_addr = '0; bus.axi_addr_w_valid = 1'b0; bus.axi_addr_w_id = '0;
        bus.axi_w_data = '0; bus.axi_w_strb = '0; bus.axi_w_valid = 1'b0;
        bus.axi_bkwd_ready = 1'b0;
        reset = 1'b1;

        // wr, addr, wdata, strb, id, resp, chk_data, data
        vt[0]  = '{1'b1, B | 32'hBFFC, 32'h1234_5678, 4'hF, 4'h1, 2'b00, 1'b0, 32'h0};
        vt[1]  = '{1'b0, B | 32'hBFFC, 32'h0,         4'h0, 4'h2, 2'b00, 1'b1, 32'h1234_5678};
        vt[2]  = '{1'b1, B | 32'hBFFC, 32'hAABB_CCDD, 4'h5, 4'h3, 2'b00, 1'b0, 32'h0};
        vt[3]  = '{1'b0, B | 32'hBFFC, 32'h0,         4'h0, 4'h4, 2'b00, 1'b1, 32'h12BB_56DD};
        vt[4]  = '{1'b0, B | 32'h0010, 32'h0,         4'h0, 4'h5, 2'b10, 1'b1, 32'h0};
        vt[5]  = '{1'b1, B | 32'h0010, 32'hDEAD_BEEF, 4'hF, 4'h6, 2'b10, 1'b0, 32'h0};
        vt[6]  = '{1'b0, B | 32'hBFFC, 32'h0,         4'h0, 4'h7, 2'b00, 1'b1, 32'h12BB_56DD};
        vt[7]  = '{1'b0, B | 32'h4000, 32'h0,         4'h0, 4'h8, CMP_EN ? 2'b00 : 2'b10, 1'b1,
                   CMP_EN ? 32'hFFFF_FFFF : 32'h0};
        vt[8]  = '{1'b0, 32'h0000_BFFC, 32'h0,        4'h0, 4'h9, 2'b00, 1'b1, 32'h12BB_56DD};
        vt[9]  = '{1'b1, B | 32'hBFFC, 32'h0,         4'h0, 4'hA, 2'b00, 1'b0, 32'h0};
        vt[10] = '{1'b0, B | 32'hBFFC, 32'h0,         4'h0, 4'hB, 2'b00, 1'b1, 32'h12BB_56DD};
        vt[11] = '{1'b1, B | 32'hBFFC, 32'h0,         4'hF, 4'hC, 2'b00, 1'b0, 32'h0};
        vt[12] = '{1'b0, B | 32'hBFFC, 32'h0,         4'h0, 4'hD, 2'b00, 1'b1, 32'h0};
        vt[13] = '{1'b0, B | 32'h4004, 32'h0,         4'h0, 4'hE, CMP_EN ? 2'b00 : 2'b10, 1'b1,
                   CMP_EN ? 32'hFFFF_FFFF : 32'h0};
        vt[14] = '{1'b0, B | 32'hBFF9, 32'h0,         4'h0, 4'hF, 2'b10, 1'b1, 32'h0};

        do_reset();
        chk("rst_arready", bus.axi_addr_r_ready, 1'b1);
        chk("rst_awready", bus.axi_addr_w_ready, 1'b1);
        chk("rst_wready", bus.axi_w_ready, 1'b1);
        chk("rst_rvalid", bus.axi_r_valid, 1'b0);
        chk("rst_rlast", bus.axi_r_last, 1'b0);
        chk("rst_rdata", bus.axi_r_data, 32'h0);
        chk("rst_rresp", bus.axi_r_resp, 2'b00);
        chk("rst_rid", bus.axi_r_id, 4'h0);
        chk("rst_bvalid", bus.axi_bkwd_valid, 1'b0);
        chk("rst_bresp", bus.axi_bkwd_resp, 2'b00);
        chk("rst_bid", bus.axi_bkwd_id, 4'h0);
        chk("rst_irq", irq, 1'b0);

        // mtime counts every clock from reset release
        repeat (10) @(negedge clock);
        do_read(B | 32'hBFF8, 4'hA, 0, d, r);
        chk("t1_resp", r, 2'b00);
        chk_range("t1_mtime_lo", d, 10, 13);

        for (int i = 0; i < 15; i++) begin
            if (vt[i].wr) begin
                do_write(vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].id, 0, 0, 0, r);
                chk($sformatf("vec%0d_bresp", i), r, vt[i].exp_resp);
            end else begin
                do_read(vt[i].addr, vt[i].id, 0, d, r);
                chk($sformatf("vec%0d_rresp", i), r, vt[i].exp_resp);
                if (vt[i].chk_data) chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
            end
        end

        // low half written to all-ones then high half cleared
        do_write(B | 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 4'h1, 0, 0, 0, r);
        chk("t2_bresp_lo", r, 2'b00);
        do_write(B | 32'hBFFC, 32'h0, 4'hF, 4'h2, 0, 0, 0, r);
        chk("t2_bresp_hi", r, 2'b00);
        repeat (3) @(negedge clock);
        do_read(B | 32'hBFF8, 4'h3, 0, d, r);
        chk_range("t2_lo_wrapped", d, 1, 40);
        do_read(B | 32'hBFFC, 4'h4, 0, d, r);
        chk("t2_hi", d, 32'h0);

        // W three cycles before AW, B stalled five cycles
        do_write(B | 32'hBFFC, 32'h55, 4'hF, 4'h3, 3, 0, 5, r);
        chk("t3_bresp", r, 2'b00);
        do_read(B | 32'hBFFC, 4'h5, 0, d, r);
        chk("t3_hi", d, 32'h55);

        // AW two cycles before W
        do_write(B | 32'hBFFC, 32'h77, 4'hF, 4'h9, 0, 2, 0, r);
        chk("t3b_bresp", r, 2'b00);
        do_read(B | 32'hBFFC, 4'h6, 0, d, r);
        chk("t3b_hi", d, 32'h77);

        // R stalled four cycles
        do_read(B | 32'hBFFC, 4'h6, 4, d, r);
        chk("t5_resp", r, 2'b00);
        chk("t5_data", d, 32'h77);

        // same-cycle read and write of mtime high returns the old value
        fork
            do_read(B | 32'hBFFC, 4'h7, 0, d, r);
            do_write(B | 32'hBFFC, 32'h9999, 4'hF, 4'h8, 0, 0, 0, r2);
        join
        chk("t7_old_value", d, 32'h77);
        chk("t7_bresp", r2, 2'b00);
        do_read(B | 32'hBFFC, 4'h1, 0, d, r);
        chk("t7_new_value", d, 32'h9999);

        if (CMP_EN) begin
            do_reset();
            do_write(B | 32'h4004, 32'h0, 4'hF, 4'h1, 0, 0, 0, r);
            do_write(B | 32'h4000, 32'd20, 4'hF, 4'h2, 0, 0, 0, r);
            chk("t6_irq_before", irq, 1'b0);
            n = 0;
            while (!irq && n < MAXW) begin
                @(negedge clock);
                n++;
            end
            if (n >= MAXW) note_fail("t6_irq_rise");
            do_read(B | 32'hBFF8, 4'h3, 0, d, r);
            chk_range("t6_mtime_at_irq", d, 21, 23);
            do_read(B | 32'h4000, 4'h4, 0, d, r);
            chk("t6_cmp_lo", d, 32'd20);
            do_write(B | 32'h4004, 32'hFFFF_FFFF, 4'hF, 4'h5, 0, 0, 0, r);
            @(negedge clock);
            chk("t6_irq_cleared", irq, 1'b0);
        end else begin
            repeat (5) @(negedge clock);
            chk("t6_irq_tied", irq, 1'b0);
        end

        // reset with an R beat outstanding and an AW latched
        @(negedge clock);
        bus.axi_addr_r_addr = B | 32'hBFF8; bus.axi_addr_r_id = 4'h5; bus.axi_addr_r_valid = 1'b1;
        bus.axi_addr_w_addr = B | 32'hBFFC; bus.axi_addr_w_id = 4'h4; bus.axi_addr_w_valid = 1'b1;
        @(negedge clock);
        bus.axi_addr_r_valid = 1'b0;
        bus.axi_addr_w_valid = 1'b0;
        chk("t8_rvalid_pending", bus.axi_r_valid, 1'b1);
        chk("t8_aw_latched", bus.axi_addr_w_ready, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t8_rvalid_dropped", bus.axi_r_valid, 1'b0);
        chk("t8_rid_cleared", bus.axi_r_id, 4'h0);
        chk("t8_arready", bus.axi_addr_r_ready, 1'b1);
        chk("t8_awready", bus.axi_addr_w_ready, 1'b1);
        chk("t8_wready", bus.axi_w_ready, 1'b1);
        chk("t8_bvalid", bus.axi_bkwd_valid, 1'b0);
        do_read(B | 32'hBFF8, 4'h6, 0, d, r);
        chk_range("t8_mtime_lo", d, 0, 4);
        do_read(B | 32'hBFFC, 4'h7, 0, d, r);
        chk("t8_mtime_hi", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
